// File: rtl/approx_ks_adder_pipe.sv
// Two-stage pipelined approximate adder: carry-isolated low segment, Kogge-Stone upper segment,
// exact reference checked on every beat, with saturating error/transaction counters.
module approx_ks_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned K     = 8,
    parameter int unsigned ERRW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err_flag,
    input  logic             err_clr,
    output logic [ERRW-1:0]  err_cnt,
    output logic [ERRW-1:0]  txn_cnt
);

    localparam int M      = int'(WIDTH) - int'(K);
    localparam int STAGES = (M > 1) ? $clog2(M) : 0;

    // Stage 1: operands, mode, carry-in and per-bit propagate/generate
    logic             s1_full_q;
    logic [WIDTH-1:0] a_q, b_q, p_q, g_q;
    logic             cin_q, mode_q;

    // Stage 2: result and mismatch flag
    logic             s2_full_q;
    logic [WIDTH:0]   sum_q;
    logic             err_q;

    logic [ERRW-1:0]  err_cnt_q, txn_cnt_q;

    logic s1_adv, in_fire, out_fire;

    assign s1_adv   = ~s2_full_q | out_ready;
    assign in_ready = rst_n & (~s1_full_q | s1_adv);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = s2_full_q & out_ready;

    // Kogge-Stone group generate/propagate over the upper segment [K..WIDTH-1]
    logic [M-1:0] gk, pk, gn, pn;

    always_comb begin
        gk = g_q[WIDTH-1:K];
        pk = p_q[WIDTH-1:K];
        gn = gk;
        pn = pk;
        for (int s = 0; s < STAGES; s++) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < M; i++) begin
                if (i >= (1 << s)) begin
                    gn[i] = gk[i] | (pk[i] & gk[i - (1 << s)]);
                    pn[i] = pk[i] & pk[i - (1 << s)];
                end
            end
            gk = gn;
            pk = pn;
        end
    end

    // Low segment carries are bare generates; the upper segment sees g[K-1] as its carry-in
    logic [WIDTH-1:0] carry;
    logic [WIDTH:0]   approx_sum, exact_sum, sum_d;
    logic             err_d;

    always_comb begin
        carry = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(K)) begin
                carry[i] = g_q[i];
            end else begin
                carry[i] = gk[i - int'(K)] | (pk[i - int'(K)] & g_q[K-1]);
            end
        end
        approx_sum        = '0;
        approx_sum[0]     = p_q[0];
        for (int i = 1; i < int'(WIDTH); i++) begin
            approx_sum[i] = p_q[i] ^ carry[i-1];
        end
        approx_sum[WIDTH] = carry[WIDTH-1];
    end

    always_comb begin
        exact_sum = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
        sum_d     = mode_q ? exact_sum : approx_sum;
        err_d     = ~mode_q & (approx_sum != exact_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_full_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            g_q       <= '0;
            cin_q     <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_full_q <= 1'b1;
                a_q       <= a;
                b_q       <= b;
                p_q       <= a ^ b;
                g_q       <= a & b;
                cin_q     <= cin;
                mode_q    <= mode;
            end else if (s1_adv) begin
                s1_full_q <= 1'b0;
            end
        end
    end

    // S2 only moves when it is empty or being drained, which keeps the result stable under stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_full_q <= 1'b0;
            sum_q     <= '0;
            err_q     <= 1'b0;
        end else if (s1_adv) begin
            s2_full_q <= s1_full_q;
            if (s1_full_q) begin
                sum_q <= sum_d;
                err_q <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            txn_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
            txn_cnt_q <= '0;
        end else if (out_fire) begin
            if (txn_cnt_q != '1) begin
                txn_cnt_q <= txn_cnt_q + ERRW'(1);
            end
            if (err_q && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERRW'(1);
            end
        end
    end

    assign out_valid = s2_full_q;
    assign sum       = sum_q;
    assign err_flag  = err_q;
    assign err_cnt   = err_cnt_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_approx_ks_adder_pipe.sv
// Scoreboard bench for approx_ks_adder_pipe (WIDTH=16, K=8, ERRW=16) with directed vectors.
module tb_approx_ks_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] sum;
    logic        err_flag;
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt, txn_cnt;

    typedef struct packed {
        logic [16:0] s;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;

    approx_ks_adder_pipe #(.WIDTH(16), .K(8), .ERRW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .err_flag  (err_flag),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                        input logic tmode, input logic [16:0] es, input logic ee);
        int tries = 0;
        @(negedge clk);
        a = ta; b = tb; cin = tcin; mode = tmode; in_valid = 1'b1;
        #1;
        while (!in_ready && tries < 200) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept a=%0h b=%0h", ta, tb);
        end else begin
            q.push_back('{s: es, e: ee});
            accepted++;
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int tries = 0;
        idle();
        while (q.size() != 0 && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
        #3;
    endtask

    // Monitor: out_ready and out_valid are stable from negedge+2 up to the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", sum);
                end else begin
                    e = q.pop_front();
                    chk("result_sum", 64'(sum), 64'(e.s));
                    chk("result_err_flag", 64'(err_flag), 64'(e.e));
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_err_flag", 64'(err_flag), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        chk("reset_txn_cnt", 64'(txn_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        // Single mismatching approximate add
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h000FC, 1'b1);
        drain();
        chk("a_err_cnt", 64'(err_cnt), 64'd1);
        chk("a_txn_cnt", 64'(txn_cnt), 64'd1);

        // Back-to-back mix of approximate and exact beats
        send(16'h1200, 16'h0340, 1'b0, 1'b0, 17'h01540, 1'b0);
        send(16'h0080, 16'h0080, 1'b0, 1'b0, 17'h00100, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h0FFFC, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h10000, 1'b0);
        send(16'h0001, 16'h0001, 1'b1, 1'b0, 17'h00002, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF, 1'b0);
        drain();
        chk("b_err_cnt", 64'(err_cnt), 64'd3);
        chk("b_txn_cnt", 64'(txn_cnt), 64'd7);

        // Clear while idle
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #3;
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
        chk("clr_txn_cnt", 64'(txn_cnt), 64'd0);

        // Backpressure: two beats fill the pipe, the third waits
        @(negedge clk);
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                send(16'h0101, 16'h0101, 1'b0, 1'b0, 17'h00202, 1'b0);
                send(16'h000F, 16'h0001, 1'b0, 1'b0, 17'h0000C, 1'b1);
                send(16'h0040, 16'h0040, 1'b0, 1'b0, 17'h00080, 1'b0);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                #3;
                chk("stall_accepted", 64'(accepted), 64'd2);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_sum_held", 64'(sum), 64'h00202);
                chk("stall_err_held", 64'(err_flag), 64'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("c_txn_cnt", 64'(txn_cnt), 64'd3);
        chk("c_err_cnt", 64'(err_cnt), 64'd1);

        // Clear coincident with a mismatching handshake
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h000FC, 1'b1);
        idle();
        begin
            int tries = 0;
            #3;
            while (!out_valid && tries < 20) begin
                @(negedge clk);
                #3;
                tries++;
            end
            chk("clrhs_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        err_clr   = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #3;
        chk("clrhs_err_cnt", 64'(err_cnt), 64'd0);
        chk("clrhs_txn_cnt", 64'(txn_cnt), 64'd0);

        // Saturation: 2^16+3 mismatching beats
        for (int i = 0; i < 65539; i++) begin
            send(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h000FC, 1'b1);
        end
        drain();
        chk("sat_err_cnt", 64'(err_cnt), 64'hFFFF);
        chk("sat_txn_cnt", 64'(txn_cnt), 64'hFFFF);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1200, 16'h0340, 1'b0, 1'b0, 17'h01540, 1'b0);
        send(16'h0080, 16'h0080, 1'b0, 1'b0, 17'h00100, 1'b0);
        idle();
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_txn_cnt", 64'(txn_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end
        send(16'h0080, 16'h0080, 1'b0, 1'b0, 17'h00100, 1'b0);
        drain();
        chk("post_rst_txn_cnt", 64'(txn_cnt), 64'd1);
        chk("post_rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
